// File: rtl/lane_alloc_queue_pointer.sv
// lane_alloc_queue_pointer: head/tail/occupancy controller for a circular
// buffer with sparse multi-lane allocation, multi-entry release at the head
// and single-cycle tail recovery. Entry storage lives in the owning queue.
//
// Optional feature macro: QUEUE_POINTER_POP_GUARD_EN
//   defined   : pops are clipped to min(popCount, count, POP_WIDTH) and a
//               sticky popUnderflow output flags any clipping.
//   undefined : pops are taken as-is; assertions flag over-pop and
//               occupancy overflow.
//
// Handshake: pushAccept is an all-or-nothing grant for the whole pushReq
// mask. When pushAccept is high, every lane with pushReq[i] set owns slot
// pushPtr[i] in that same cycle; when low, nothing is allocated.
module lane_alloc_queue_pointer #(
    parameter int SIZE             = 16,
    parameter int PUSH_WIDTH       = 2,
    parameter int POP_WIDTH        = 2,
    parameter int INITIAL_HEAD_PTR = 0,
    parameter int INITIAL_TAIL_PTR = 0,
    parameter int INITIAL_COUNT    = 0,
    localparam int IDX = $clog2(SIZE),
    localparam int CW  = IDX + 1,
    localparam int PCW = $clog2(POP_WIDTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PUSH_WIDTH-1:0]      pushReq,
    output logic                       pushAccept,
    output logic [PUSH_WIDTH*IDX-1:0]  pushPtr,
    input  logic [PCW-1:0]             popCount,
    input  logic                       recover,
    input  logic [IDX-1:0]             recoverTailPtr,
    output logic [IDX-1:0]             headPtr,
    output logic [IDX-1:0]             tailPtr,
    output logic [CW-1:0]              count,
    output logic [CW-1:0]              freeCount,
    output logic                       full,
    output logic                       empty
`ifdef QUEUE_POINTER_POP_GUARD_EN
    ,
    output logic                       popUnderflow
`endif
);

    logic [IDX-1:0] r_head;
    logic [IDX-1:0] r_tail;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  r_free;
    logic           r_full;
    logic           r_empty;

    logic [CW-1:0]  w_req_num;
    logic [CW-1:0]  w_slot [PUSH_WIDTH];
    logic           w_accept;
    logic [CW-1:0]  w_pop_req;
    logic [CW-1:0]  w_eff_pop;
    logic [IDX-1:0] w_head_next;
    logic [IDX-1:0] w_tail_next;
    logic [CW-1:0]  w_recover_count;
    logic [CW-1:0]  w_count_next;

    // Modular add for non-power-of-two sizes: one wide add, one conditional
    // subtract. Operands are always < SIZE so a single subtract suffices.
    function automatic logic [IDX-1:0] wrap_add(input logic [IDX-1:0] base,
                                                input logic [CW-1:0]  inc);
        logic [CW-1:0] sum;
        sum = {1'b0, base} + inc;
        if (sum >= CW'(SIZE)) begin
            sum = sum - CW'(SIZE);
        end
        return sum[IDX-1:0];
    endfunction

    // Prefix popcount: each requesting lane gets the next compacted slot.
    always_comb begin
        w_req_num = '0;
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            w_slot[i] = w_req_num;
            if (pushReq[i]) begin
                w_req_num = w_req_num + CW'(1);
            end
        end
    end

    // Grant against registered free space only; recovery blocks allocation.
    always_comb begin
        w_accept = !recover && (w_req_num <= r_free);
        pushPtr  = '0;
        for (int i = 0; i < PUSH_WIDTH; i++) begin
            pushPtr[i*IDX +: IDX] = wrap_add(r_tail, w_slot[i]);
        end
    end

    assign w_pop_req = CW'(popCount);

`ifdef QUEUE_POINTER_POP_GUARD_EN
    logic w_clip;
    logic r_pop_uf;

    // Clip the pop to what is held and to the lane limit.
    always_comb begin
        w_eff_pop = w_pop_req;
        if (w_eff_pop > r_count) begin
            w_eff_pop = r_count;
        end
        if (w_eff_pop > CW'(POP_WIDTH)) begin
            w_eff_pop = CW'(POP_WIDTH);
        end
        w_clip = (w_eff_pop != w_pop_req);
    end

    // Sticky record that some pop request was clipped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pop_uf <= 1'b0;
        end else begin
            r_pop_uf <= r_pop_uf | w_clip;
        end
    end

    assign popUnderflow = r_pop_uf;
`else
    assign w_eff_pop = w_pop_req;

    // Releasing more than is held corrupts occupancy: a caller bug.
    a_pop_le_count: assert property (@(posedge clk) disable iff (rst)
        w_pop_req <= r_count);
    a_count_le_size: assert property (@(posedge clk) disable iff (rst)
        r_count <= CW'(SIZE));
`endif

    // Next pointers and occupancy; recovery recounts from the post-pop head.
    always_comb begin
        w_head_next = wrap_add(r_head, w_eff_pop);
        if (recoverTailPtr >= w_head_next) begin
            w_recover_count = {1'b0, recoverTailPtr} - {1'b0, w_head_next};
        end else begin
            w_recover_count = {1'b0, recoverTailPtr} + CW'(SIZE) - {1'b0, w_head_next};
        end
        w_tail_next  = r_tail;
        w_count_next = r_count - w_eff_pop;
        if (recover) begin
            w_tail_next  = recoverTailPtr;
            w_count_next = w_recover_count;
        end else if (w_accept) begin
            w_tail_next  = wrap_add(r_tail, w_req_num);
            w_count_next = r_count + w_req_num - w_eff_pop;
        end
    end

    // Pointer and occupancy state, with status flags registered alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= IDX'(INITIAL_HEAD_PTR);
            r_tail  <= IDX'(INITIAL_TAIL_PTR);
            r_count <= CW'(INITIAL_COUNT);
            r_free  <= CW'(SIZE - INITIAL_COUNT);
            r_full  <= (INITIAL_COUNT == SIZE);
            r_empty <= (INITIAL_COUNT == 0);
        end else begin
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
            r_count <= w_count_next;
            r_free  <= CW'(SIZE) - w_count_next;
            r_full  <= (w_count_next == CW'(SIZE));
            r_empty <= (w_count_next == '0);
        end
    end

    assign pushAccept = w_accept;
    assign headPtr    = r_head;
    assign tailPtr    = r_tail;
    assign count      = r_count;
    assign freeCount  = r_free;
    assign full       = r_full;
    assign empty      = r_empty;

endmodule

// File: tb/tb_lane_alloc_queue_pointer.sv
// Bench for lane_alloc_queue_pointer (SIZE=16, PUSH_WIDTH=4, POP_WIDTH=2):
// a table of directed vectors, a random phase against a small modular model,
// mid-operation reset, and the pop-guard sequence when
// QUEUE_POINTER_POP_GUARD_EN is defined.
module tb_lane_alloc_queue_pointer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  pushReq;
  logic        pushAccept;
  logic [15:0] pushPtr;
  logic [1:0]  popCount;
  logic        recover;
  logic [3:0]  recoverTailPtr;
  logic [3:0]  headPtr;
  logic [3:0]  tailPtr;
  logic [4:0]  count;
  logic [4:0]  freeCount;
  logic        full;
  logic        empty;
`ifdef QUEUE_POINTER_POP_GUARD_EN
  logic        popUnderflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // {head, tail, count, free, full, empty}
  logic [19:0] exp_q[$];

  typedef struct {
    logic [3:0]  req;
    logic [1:0]  pop;
    logic        rec;
    logic [3:0]  rtp;
    logic        acc;
    logic [15:0] ptr;
    logic [3:0]  head;
    logic [3:0]  tail;
    logic [4:0]  cnt;
  } vec_t;

  vec_t vecs[23];

  int m_head, m_tail, m_count, rn, k, nh;
  logic [3:0]  r_req;
  logic [1:0]  r_pop;
  logic        r_rec;
  logic [3:0]  r_rtp;
  logic        r_acc;
  logic [15:0] r_ptr;

  lane_alloc_queue_pointer #(
    .SIZE(16), .PUSH_WIDTH(4), .POP_WIDTH(2),
    .INITIAL_HEAD_PTR(0), .INITIAL_TAIL_PTR(0), .INITIAL_COUNT(0)
  ) dut (
    .clk(clk), .rst(rst),
    .pushReq(pushReq), .pushAccept(pushAccept), .pushPtr(pushPtr),
    .popCount(popCount), .recover(recover), .recoverTailPtr(recoverTailPtr),
    .headPtr(headPtr), .tailPtr(tailPtr), .count(count), .freeCount(freeCount),
    .full(full), .empty(empty)
`ifdef QUEUE_POINTER_POP_GUARD_EN
    , .popUnderflow(popUnderflow)
`endif
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " headPtr"}, 32'(headPtr), 0);
    check({tag, " tailPtr"}, 32'(tailPtr), 0);
    check({tag, " count"}, 32'(count), 0);
    check({tag, " freeCount"}, 32'(freeCount), 16);
    check({tag, " full"}, 32'(full), 0);
    check({tag, " empty"}, 32'(empty), 1);
`ifdef QUEUE_POINTER_POP_GUARD_EN
    check({tag, " popUnderflow"}, 32'(popUnderflow), 0);
`endif
  endtask

  // driver: apply one cycle, check combinational grant, score registered state
  task automatic step(input logic [3:0] req, input logic [1:0] pop, input logic rec,
                      input logic [3:0] rtp, input logic acc, input logic [15:0] ptr,
                      input logic [3:0] eh, input logic [3:0] et, input logic [4:0] ec);
    logic [19:0] e;
    @(negedge clk);
    pushReq = req;
    popCount = pop;
    recover = rec;
    recoverTailPtr = rtp;
    #1;
    check("pushAccept", 32'(pushAccept), 32'(acc));
    for (int i = 0; i < 4; i++) begin
      if (req[i] && acc) begin
        check($sformatf("pushPtr[%0d]", i), 32'(pushPtr[i*4 +: 4]), 32'(ptr[i*4 +: 4]));
      end
    end
    exp_q.push_back({eh, et, ec, 5'(16 - int'(ec)), ec == 5'd16, ec == 5'd0});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("headPtr", 32'(headPtr), 32'(e[19:16]));
    check("tailPtr", 32'(tailPtr), 32'(e[15:12]));
    check("count", 32'(count), 32'(e[11:7]));
    check("freeCount", 32'(freeCount), 32'(e[6:2]));
    check("full", 32'(full), 32'(e[1]));
    check("empty", 32'(empty), 32'(e[0]));
  endtask

  initial begin
    //           req      pop   rec   rtp    acc   ptr       head   tail   cnt
    vecs[0]  = '{4'h0, 2'd0, 1'b1, 4'd14, 1'b0, 16'h0000, 4'd0,  4'd14, 5'd14};
    vecs[1]  = '{4'h7, 2'd2, 1'b0, 4'd0,  1'b0, 16'h0000, 4'd2,  4'd14, 5'd12};
    vecs[2]  = '{4'h7, 2'd0, 1'b0, 4'd0,  1'b1, 16'h00FE, 4'd2,  4'd1,  5'd15};
    vecs[3]  = '{4'h1, 2'd2, 1'b1, 4'd14, 1'b0, 16'h0000, 4'd4,  4'd14, 5'd10};
    vecs[4]  = '{4'h0, 2'd2, 1'b0, 4'd0,  1'b1, 16'h0000, 4'd6,  4'd14, 5'd8};
    vecs[5]  = '{4'h0, 2'd2, 1'b0, 4'd0,  1'b1, 16'h0000, 4'd8,  4'd14, 5'd6};
    vecs[6]  = '{4'h0, 2'd2, 1'b0, 4'd0,  1'b1, 16'h0000, 4'd10, 4'd14, 5'd4};
    vecs[7]  = '{4'h0, 2'd2, 1'b0, 4'd0,  1'b1, 16'h0000, 4'd12, 4'd14, 5'd2};
    vecs[8]  = '{4'h0, 2'd2, 1'b0, 4'd0,  1'b1, 16'h0000, 4'd14, 4'd14, 5'd0};
    vecs[9]  = '{4'hA, 2'd0, 1'b0, 4'd0,  1'b1, 16'hF0E0, 4'd14, 4'd0,  5'd2};
    vecs[10] = '{4'h0, 2'd1, 1'b1, 4'd15, 1'b0, 16'h0000, 4'd15, 4'd15, 5'd0};
    vecs[11] = '{4'hF, 2'd0, 1'b0, 4'd0,  1'b1, 16'h210F, 4'd15, 4'd3,  5'd4};
    vecs[12] = '{4'h0, 2'd2, 1'b1, 4'd12, 1'b0, 16'h0000, 4'd1,  4'd12, 5'd11};
    vecs[13] = '{4'h0, 2'd2, 1'b0, 4'd0,  1'b1, 16'h0000, 4'd3,  4'd12, 5'd9};
    vecs[14] = '{4'h0, 2'd2, 1'b0, 4'd0,  1'b1, 16'h0000, 4'd5,  4'd12, 5'd7};
    vecs[15] = '{4'h1, 2'd2, 1'b1, 4'd9,  1'b0, 16'h0000, 4'd7,  4'd9,  5'd2};
    vecs[16] = '{4'h3, 2'd0, 1'b0, 4'd0,  1'b1, 16'h00A9, 4'd7,  4'd11, 5'd4};
    vecs[17] = '{4'h0, 2'd0, 1'b1, 4'd7,  1'b0, 16'h0000, 4'd7,  4'd7,  5'd0};
    vecs[18] = '{4'h0, 2'd0, 1'b1, 4'd6,  1'b0, 16'h0000, 4'd7,  4'd6,  5'd15};
    vecs[19] = '{4'h1, 2'd0, 1'b0, 4'd0,  1'b1, 16'h0006, 4'd7,  4'd7,  5'd16};
    vecs[20] = '{4'h1, 2'd0, 1'b0, 4'd0,  1'b0, 16'h0000, 4'd7,  4'd7,  5'd16};
    vecs[21] = '{4'h0, 2'd0, 1'b0, 4'd0,  1'b1, 16'h0000, 4'd7,  4'd7,  5'd16};
    vecs[22] = '{4'h0, 2'd2, 1'b0, 4'd0,  1'b1, 16'h0000, 4'd9,  4'd7,  5'd14};

    // reset
    rst = 1'b1;
    pushReq = '0;
    popCount = '0;
    recover = 1'b0;
    recoverTailPtr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    pushReq = 4'hF;
    #1;
    check("reset pushAccept", 32'(pushAccept), 1);
    pushReq = '0;
    rst = 1'b0;

    // directed table
    for (int v = 0; v < 23; v++) begin
      step(vecs[v].req, vecs[v].pop, vecs[v].rec, vecs[v].rtp, vecs[v].acc,
           vecs[v].ptr, vecs[v].head, vecs[v].tail, vecs[v].cnt);
    end

    // random phase against a modular reference model
    m_head = 9;
    m_tail = 7;
    m_count = 14;
    for (int n = 0; n < 300; n++) begin
      r_req = 4'($urandom_range(0, 15));
      r_rec = ($urandom_range(0, 9) == 0);
      r_rtp = 4'($urandom_range(0, 15));
      r_pop = 2'($urandom_range(0, (m_count < 2) ? m_count : 2));
      rn = 0;
      for (int i = 0; i < 4; i++) rn += int'(r_req[i]);
      r_acc = !r_rec && (rn <= 16 - m_count);
      r_ptr = '0;
      k = 0;
      for (int i = 0; i < 4; i++) begin
        if (r_req[i]) begin
          r_ptr[i*4 +: 4] = 4'((m_tail + k) % 16);
          k++;
        end
      end
      nh = (m_head + int'(r_pop)) % 16;
      if (r_rec) begin
        m_tail = int'(r_rtp);
        m_count = (int'(r_rtp) - nh + 16) % 16;
      end else begin
        if (r_acc) begin
          m_tail = (m_tail + rn) % 16;
          m_count = m_count + rn;
        end
        m_count = m_count - int'(r_pop);
      end
      m_head = nh;
      step(r_req, r_pop, r_rec, r_rtp, r_acc, r_ptr,
           4'(m_head), 4'(m_tail), 5'(m_count));
    end

    // reset asserted mid-operation overrides all inputs
    @(negedge clk);
    rst = 1'b1;
    pushReq = 4'hF;
    popCount = 2'd1;
    recover = 1'b1;
    recoverTailPtr = 4'd5;
    @(posedge clk);
    #1;
    check_reset_state("midreset");
    rst = 1'b0;
    pushReq = '0;
    popCount = '0;
    recover = 1'b0;
    recoverTailPtr = '0;

`ifdef QUEUE_POINTER_POP_GUARD_EN
    // over-pop is clipped to the held count and flagged stickily
    step(4'h0, 2'd0, 1'b1, 4'd1, 1'b0, 16'h0000, 4'd0, 4'd1, 5'd1);
    step(4'h0, 2'd2, 1'b0, 4'd0, 1'b1, 16'h0000, 4'd1, 4'd1, 5'd0);
    check("popUnderflow set", 32'(popUnderflow), 1);
    step(4'h0, 2'd0, 1'b0, 4'd0, 1'b1, 16'h0000, 4'd1, 4'd1, 5'd0);
    check("popUnderflow sticky", 32'(popUnderflow), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("guard reset");
    rst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
